// File: rtl/jk_stim_pkg.sv
// Shared types and helpers for the JK flip-flop stimulus/check sequencer (jk_stim_seq).
// The optional response signature is enabled with the SIG_MISR_EN macro.
package jk_stim_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  typedef struct packed {
    jk_op_e op;
    logic   exp;
  } cmd_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Pin pattern {j,k} that makes the flop perform the requested operation.
  function automatic logic [1:0] op_to_jk(jk_op_e op);
    logic [1:0] jk;
    case (op)
      HOLD:    jk = 2'b00;
      RST:     jk = 2'b01;
      SET:     jk = 2'b10;
      TGL:     jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_stim_seq_if.sv
// Command stream (valid/ready plus payload) into the JK stimulus sequencer.
interface jk_stim_seq_if;

  logic                cmd_valid;
  logic                cmd_ready;
  jk_stim_pkg::jk_op_e cmd_op;
  logic                cmd_exp;

  modport master (output cmd_valid, output cmd_op, output cmd_exp, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_exp, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO holding {op, exp}; full/empty derive from the registered count.
module jk_cmd_fifo
  import jk_stim_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cmd_t                     data_i,
  input  logic                     pop_i,
  output cmd_t                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/jk_stim_seq.sv
// JK flop stimulus/check stage: pulses j/k per queued command, checks q one cycle later.
// Define SIG_MISR_EN to add the misr_sig response signature.
module jk_stim_seq
  import jk_stim_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
`ifdef SIG_MISR_EN
  , parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY = MISR_W'(DEFAULT_POLY)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_stim_seq_if.slave     cmd,
  output logic             j,
  output logic             k,
  input  logic             q_obs,
  input  logic             clr_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
`ifdef SIG_MISR_EN
  , output logic [MISR_W-1:0] misr_sig
`endif
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  cmd_t             push_data, head;
  logic             fifo_full, fifo_empty, pop, load, check, mismatch;
  logic [AW:0]      fifo_count;
  logic             j_q, j_d, k_q, k_d, exp_q, exp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
  logic             sticky_q, sticky_d;

  assign push_data     = '{op: cmd.cmd_op, exp: cmd.cmd_exp};
  assign cmd.cmd_ready = !fifo_full;

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd.cmd_valid),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // CHECK may launch the next command directly, giving two cycles per command.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    check   = 1'b0;
    pop     = 1'b0;
    j_d     = 1'b0;
    k_d     = 1'b0;
    exp_d   = exp_q;
    case (state_q)
      IDLE:  load = !fifo_empty;
      DRIVE: state_d = CHECK;
      CHECK: begin
        check   = 1'b1;
        state_d = IDLE;
        load    = !fifo_empty;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop        = 1'b1;
      {j_d, k_d} = op_to_jk(head.op);
      exp_d      = head.exp;
      state_d    = DRIVE;
    end
  end

  // A clear in the same cycle as a mismatch still records that mismatch.
  always_comb begin
    mismatch  = check && (q_obs != exp_q);
    cnt_base  = clr_err ? '0 : err_cnt_q;
    sticky_d  = (clr_err ? 1'b0 : sticky_q) | mismatch;
    err_cnt_d = cnt_base;
    if (mismatch && (cnt_base != CNT_MAX)) begin
      err_cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      exp_q     <= 1'b0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      k_q       <= k_d;
      exp_q     <= exp_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign j          = j_q;
  assign k          = k_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = sticky_q;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);

`ifdef SIG_MISR_EN
  logic [MISR_W-1:0] sig_q, sig_d, sig_base;

  always_comb begin
    sig_base = clr_err ? '1 : sig_q;
    sig_d    = sig_base;
    if (check) begin
      sig_d = {sig_base[MISR_W-2:0], 1'b0}
            ^ ({MISR_W{sig_base[MISR_W-1]}} & POLY)
            ^ MISR_W'(q_obs);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '1;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign misr_sig = sig_q;
`endif

endmodule
